// File: rtl/lives_manager.sv
// lives_manager
// Game-state sequencer for pong. It walks the start, serve, play, respawn and
// game-over sequence, owns the remaining-lives count shown by the lives
// painter, and issues a one-cycle serve pulse to the ball logic.
//
// State table:
//   state      | meaning
//   IDLE       | no game running, waiting for start
//   SERVE_WAIT | counting frame ticks before launching the ball
//   PLAYING    | ball in play, reacting to miss / extra_life
//   GAME_OVER  | holding game_over for a number of frames, then back to IDLE
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   start        in   start request (level, sampled high in IDLE)
//   miss         in   one-cycle pulse when the ball leaves the field
//   extra_life   in   one-cycle pulse awarding a life
//   lives        out  remaining lives (registered)
//   serve        out  one-cycle pulse on entry into PLAYING
//   ball_active  out  ball in play
//   game_over    out  high during GAME_OVER
//   state        out  FSM state for debug (IDLE=0 .. GAME_OVER=3)
module lives_manager #(
  parameter logic [1:0] START_LIVES     = 2'd3,
  parameter int         RESPAWN_FRAMES  = 60,
  parameter int         GAMEOVER_FRAMES = 180,
  parameter int         CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss,
  input  logic       extra_life,
  output logic [1:0] lives,
  output logic       serve,
  output logic       ball_active,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAYING    = 3'd2,
    GAME_OVER  = 3'd3
  } state_e;

  // Delay counters hold "frames remaining minus one", so the terminal frame
  // is the one that arrives while the count is already zero.
  localparam logic [CNT_W-1:0] RESPAWN_LOAD  = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAMEOVER_LOAD = CNT_W'(GAMEOVER_FRAMES - 1);

  state_e           state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             serve_q, serve_d;
  logic             ball_active_q, ball_active_d;
  logic             game_over_q, game_over_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lives_q       <= 2'd0;
      cnt_q         <= '0;
      serve_q       <= 1'b0;
      ball_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      serve_q       <= serve_d;
      ball_active_q <= ball_active_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    cnt_d         = cnt_q;
    serve_d       = 1'b0;
    ball_active_d = ball_active_q;
    game_over_d   = game_over_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          lives_d = START_LIVES;
          cnt_d   = RESPAWN_LOAD;
          state_d = SERVE_WAIT;
        end
      end

      SERVE_WAIT: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            serve_d       = 1'b1;
            ball_active_d = 1'b1;
            state_d       = PLAYING;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      PLAYING: begin
        if (miss) begin
          ball_active_d = 1'b0;
          // lives==0 here cannot happen legally; treat it as the last life
          // so the subtract below can never wrap to 3.
          if (lives_q <= 2'd1) begin
            lives_d     = 2'd0;
            cnt_d       = GAMEOVER_LOAD;
            game_over_d = 1'b1;
            state_d     = GAME_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            cnt_d   = RESPAWN_LOAD;
            state_d = SERVE_WAIT;
          end
        end else if (extra_life) begin
          lives_d = (lives_q == 2'd3) ? 2'd3 : lives_q + 2'd1;
        end
      end

      GAME_OVER: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            game_over_d = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign lives       = lives_q;
  assign serve       = serve_q;
  assign ball_active = ball_active_q;
  assign game_over   = game_over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_lives_manager.sv
module tb_lives_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss = 1'b0;
  logic       extra_life = 1'b0;
  logic [1:0] lives;
  logic       serve;
  logic       ball_active;
  logic       game_over;
  logic [2:0] state;

  int tests  = 0;
  int failed = 0;

  lives_manager #(
    .START_LIVES    (2'd3),
    .RESPAWN_FRAMES (4),
    .GAMEOVER_FRAMES(3),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .miss       (miss),
    .extra_life (extra_life),
    .lives      (lives),
    .serve      (serve),
    .ball_active(ball_active),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Apply inputs for one clock edge, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic f, input logic s,
                     input logic m, input logic e);
    rst = r; frame_tick = f; start = s; miss = m; extra_life = e;
    @(posedge clk);
    #1;
    rst = 0; frame_tick = 0; start = 0; miss = 0; extra_life = 0;
  endtask

  // From a fresh SERVE_WAIT load (4 frames): three frame ticks with idle
  // cycles between must not serve; the fourth must serve into PLAYING.
  task automatic test_serve_wait(input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      tests++;
      if (serve !== 1'b0 || state !== 3'd1) begin
        failed++;
        $display("FAIL %s_early tick%0d serve=%0b state=%0d exp serve=0 state=1", tag, i, serve, state);
      end
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (serve !== 1'b1 || state !== 3'd2 || ball_active !== 1'b1) begin
      failed++;
      $display("FAIL %s_serve serve=%0b state=%0d ba=%0b exp 1/2/1", tag, serve, state, ball_active);
    end
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (serve !== 1'b0 || state !== 3'd2) begin
      failed++;
      $display("FAIL %s_serve_pulse serve=%0b state=%0d exp 0/2", tag, serve, state);
    end
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0);
    tests++;
    if ({state, lives, serve, ball_active, game_over} !== 8'd0) begin
      failed++;
      $display("FAIL reset state=%0d lives=%0d serve=%0b ba=%0b go=%0b exp all 0",
               state, lives, serve, ball_active, game_over);
    end
    // IDLE ignores miss / extra_life / frame_tick
    cyc(0, 1, 0, 1, 1);
    tests++;
    if (state !== 3'd0 || lives !== 2'd0) begin
      failed++;
      $display("FAIL idle_ignore state=%0d lives=%0d exp 0/0", state, lives);
    end
  endtask

  task automatic test_start;
    // frame_tick in the start cycle must not be counted
    cyc(0, 1, 1, 0, 0);
    tests++;
    if (state !== 3'd1 || lives !== 2'd3 || serve !== 1'b0) begin
      failed++;
      $display("FAIL start state=%0d lives=%0d serve=%0b exp 1/3/0", state, lives, serve);
    end
    test_serve_wait("start");
  endtask

  task automatic test_miss_respawn;
    cyc(0, 0, 0, 1, 0);
    tests++;
    if (lives !== 2'd2 || ball_active !== 1'b0 || state !== 3'd1) begin
      failed++;
      $display("FAIL miss lives=%0d ba=%0b state=%0d exp 2/0/1", lives, ball_active, state);
    end
    test_serve_wait("respawn");
  endtask

  task automatic test_extra_life;
    cyc(0, 0, 0, 0, 1);
    tests++;
    if (lives !== 2'd3) begin
      failed++;
      $display("FAIL extra_2to3 lives=%0d exp 3", lives);
    end
    cyc(0, 0, 0, 0, 1);
    tests++;
    if (lives !== 2'd3) begin
      failed++;
      $display("FAIL extra_sat lives=%0d exp 3", lives);
    end
    cyc(0, 0, 0, 1, 1);
    tests++;
    if (lives !== 2'd2 || state !== 3'd1) begin
      failed++;
      $display("FAIL miss_wins lives=%0d state=%0d exp 2/1", lives, state);
    end
  endtask

  task automatic test_serve_wait_ignore;
    // SERVE_WAIT with 4 frames to go, lives=2
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    tests++;
    if (lives !== 2'd2 || state !== 3'd1 || serve !== 1'b0) begin
      failed++;
      $display("FAIL sw_ignore lives=%0d state=%0d serve=%0b exp 2/1/0", lives, state, serve);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (state !== 3'd1 || serve !== 1'b0) begin
      failed++;
      $display("FAIL sw_ignore_early state=%0d serve=%0b exp 1/0", state, serve);
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (state !== 3'd2 || serve !== 1'b1) begin
      failed++;
      $display("FAIL sw_ignore_serve state=%0d serve=%0b exp 2/1", state, serve);
    end
  endtask

  task automatic test_game_over;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    test_serve_wait("go_a");
    cyc(0, 0, 0, 1, 0);
    test_serve_wait("go_b");
    cyc(0, 0, 0, 1, 0);
    tests++;
    if (lives !== 2'd1 || state !== 3'd1) begin
      failed++;
      $display("FAIL go_lives1 lives=%0d state=%0d exp 1/1", lives, state);
    end
    test_serve_wait("go_c");
    cyc(0, 1, 0, 1, 0);
    tests++;
    if (lives !== 2'd0 || game_over !== 1'b1 || state !== 3'd3 || ball_active !== 1'b0) begin
      failed++;
      $display("FAIL go_enter lives=%0d go=%0b state=%0d ba=%0b exp 0/1/3/0",
               lives, game_over, state, ball_active);
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 1);
    tests++;
    if (game_over !== 1'b1 || state !== 3'd3 || lives !== 2'd0) begin
      failed++;
      $display("FAIL go_hold go=%0b state=%0d lives=%0d exp 1/3/0", game_over, state, lives);
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (game_over !== 1'b0 || state !== 3'd0 || lives !== 2'd0) begin
      failed++;
      $display("FAIL go_exit go=%0b state=%0d lives=%0d exp 0/0/0", game_over, state, lives);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    tests++;
    if ({state, lives, serve, ball_active, game_over} !== 8'd0) begin
      failed++;
      $display("FAIL rst_sw state=%0d lives=%0d serve=%0b ba=%0b go=%0b exp all 0",
               state, lives, serve, ball_active, game_over);
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
    tests++;
    if (state !== 3'd0 || serve !== 1'b0) begin
      failed++;
      $display("FAIL rst_no_serve state=%0d serve=%0b exp 0/0", state, serve);
    end
    cyc(0, 0, 1, 0, 0);
    test_serve_wait("rst_play");
    cyc(1, 0, 0, 1, 1);
    tests++;
    if ({state, lives, serve, ball_active, game_over} !== 8'd0) begin
      failed++;
      $display("FAIL rst_play state=%0d lives=%0d serve=%0b ba=%0b go=%0b exp all 0",
               state, lives, serve, ball_active, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss_respawn();
    test_extra_life();
    test_serve_wait_ignore();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
